// File: rtl/pll_phase_stepper.sv
// Phase-rotation sequencer for PF_CCC dynamic phase control: turns one request
// into the SEL/DIRECTION/ROTATE/LOAD_PHASE_N pin sequence and tracks phase per output.
module pll_phase_stepper #(
    parameter  int NUM_OUT         = 4,
    parameter  int STEPS_PER_CYCLE = 8,
    parameter  int STEP_W          = 8,
    parameter  int ROT_HI_CYCLES   = 2,
    parameter  int SETTLE_CYCLES   = 4,
    localparam int PW              = $clog2(STEPS_PER_CYCLE)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  pll_lock,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NUM_OUT-1:0]    req_sel,
    input  logic                  req_dir,
    input  logic [STEP_W-1:0]     req_steps,
    output logic [NUM_OUT-1:0]    phase_out_sel,
    output logic                  phase_direction,
    output logic                  phase_rotate,
    output logic                  load_phase_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [NUM_OUT*PW-1:0] phase_pos
);

    localparam int TMAX = (ROT_HI_CYCLES > SETTLE_CYCLES) ? ROT_HI_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ROT_HI,
        S_ROT_LO,
        S_LOAD,
        S_DONE
    } state_t;

    state_t            state;
    logic [STEP_W-1:0] cnt;
    logic [TW-1:0]     timer;

    assign req_ready = (state == S_IDLE) & pll_lock & arst_n;
    assign busy      = (state != S_IDLE);

    // phase_out_sel/phase_direction double as the latched request SEL/DIR,
    // since they are held unchanged from SETUP through LOAD.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state           <= S_IDLE;
            phase_out_sel   <= '0;
            phase_direction <= 1'b0;
            phase_rotate    <= 1'b0;
            load_phase_n    <= 1'b1;
            done            <= 1'b0;
            err             <= 1'b0;
            cnt             <= '0;
            timer           <= '0;
            phase_pos       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state != S_IDLE && !pll_lock) begin
                // Relock resets the PLL phase, so tracked positions are void.
                state           <= S_IDLE;
                err             <= 1'b1;
                phase_out_sel   <= '0;
                phase_direction <= 1'b0;
                phase_rotate    <= 1'b0;
                load_phase_n    <= 1'b1;
                phase_pos       <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!pll_lock) begin
                            phase_pos <= '0;
                        end else if (req_valid) begin
                            cnt <= req_steps;
                            if (req_steps == '0 || req_sel == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state           <= S_SETUP;
                                phase_out_sel   <= req_sel;
                                phase_direction <= req_dir;
                            end
                        end
                    end
                    S_SETUP: begin
                        state        <= S_ROT_HI;
                        phase_rotate <= 1'b1;
                        timer        <= TW'(ROT_HI_CYCLES - 1);
                    end
                    S_ROT_HI: begin
                        if (timer == '0) begin
                            cnt <= cnt - 1'b1;
                            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                                if (phase_out_sel[i]) begin
                                    if (phase_direction)
                                        phase_pos[i*PW +: PW] <= phase_pos[i*PW +: PW] + PW'(1);
                                    else
                                        phase_pos[i*PW +: PW] <= phase_pos[i*PW +: PW] - PW'(1);
                                end
                            end
                            phase_rotate <= 1'b0;
                            timer        <= TW'(SETTLE_CYCLES - 1);
                            state        <= S_ROT_LO;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_ROT_LO: begin
                        if (timer == '0) begin
                            if (cnt != '0) begin
                                state        <= S_ROT_HI;
                                phase_rotate <= 1'b1;
                                timer        <= TW'(ROT_HI_CYCLES - 1);
                            end else begin
                                state        <= S_LOAD;
                                load_phase_n <= 1'b0;
                            end
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_LOAD: begin
                        state           <= S_DONE;
                        load_phase_n    <= 1'b1;
                        done            <= 1'b1;
                        phase_out_sel   <= '0;
                        phase_direction <= 1'b0;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
